// File: rtl/instr_encoder_if.sv
// Handshake bundle for instr_encoder: field bundle in, encoded word out.
// The encoder uses the slave modport; the producer/consumer side uses master.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32 R/I/S/B instruction encoder with one output register stage and an address counter.
// Define INSTR_ENCODER_RANGE_CHECK_EN to flag immediates that do not fit their field.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_S = 2'd2;
  localparam logic [1:0] FMT_B = 2'd3;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] enc_word;
  logic        in_ready;
  logic        accept;

  assign in_ready = (state_q == EMPTY) || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    enc_word = 32'h0;
    case (bus.in_fmt)
      FMT_R: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         bus.in_rd, 7'b0110011};
      FMT_I: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                         bus.in_rd, 7'b0010011};
      FMT_S: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         bus.in_imm[4:0], 7'b0100011};
      FMT_B: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                         bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
      default: enc_word = 32'h0;
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic enc_err;
  logic err_q, err_d;

  // An immediate fits when every bit above the field's sign bit equals that sign bit.
  always_comb begin
    enc_err = 1'b0;
    case (bus.in_fmt)
      FMT_I, FMT_S: enc_err = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
      FMT_B:        enc_err = !((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12]))
                              || bus.in_imm[0];
      default:      enc_err = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    addr_d  = addr_q;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    err_d   = err_q;
`endif
    if (accept) begin
      // Accept wins over drain, so a simultaneous transfer refills with no bubble.
      state_d = FULL;
      instr_d = enc_word;
      addr_d  = pc_q;
      pc_d    = pc_q + 32'd4;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
      err_d   = enc_err;
`endif
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      pc_q    <= BASE_ADDR;
      instr_q <= 32'h0;
      addr_q  <= 32'h0;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  assign bus.out_err   = err_q;
`else
  assign bus.out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases, then randomized traffic
// against an arithmetic reference model; a second instance covers address wrap.
module tb_instr_encoder;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_encoder_if if_a ();
  instr_encoder_if if_b ();

  instr_encoder #(.BASE_ADDR(32'h0000_0000)) u_dut (
    .clk   (clk),
    .reset (rst_a),
    .bus   (if_a)
  );

  instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) u_wrap (
    .clk   (clk),
    .reset (rst_b),
    .bus   (if_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int fmt, input int f3, input int f7,
                       input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    if_a.in_valid  = v;
    if_a.in_fmt    = 2'(fmt);
    if_a.in_funct3 = 3'(f3);
    if_a.in_funct7 = 7'(f7);
    if_a.in_rd     = 5'(rd);
    if_a.in_rs1    = 5'(rs1);
    if_a.in_rs2    = 5'(rs2);
    if_a.in_imm    = imm;
  endtask

  // Reference encoding built from field weights (powers of two) rather than bit slicing.
  function automatic logic [31:0] model_word(input int fmt, input int f3, input int f7,
                                             input int rd, input int rs1, input int rs2,
                                             input logic [31:0] imm);
    longint opc [4] = '{51, 19, 35, 99};
    longint u = longint'(imm);
    longint w;
    case (fmt)
      0: w = opc[0] + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * (64'd1 << 20)
             + f7 * (64'd1 << 25);
      1: w = opc[1] + rd * 128 + f3 * 4096 + rs1 * 32768 + (u % 4096) * (64'd1 << 20);
      2: w = opc[2] + (u % 32) * 128 + f3 * 4096 + rs1 * 32768 + rs2 * (64'd1 << 20)
             + ((u / 32) % 128) * (64'd1 << 25);
      default: w = opc[3] + ((u / 2048) % 2) * 128 + ((u / 2) % 16) * 256 + f3 * 4096
             + rs1 * 32768 + rs2 * (64'd1 << 20) + ((u / 32) % 64) * (64'd1 << 25)
             + ((u / 4096) % 2) * (64'd1 << 31);
    endcase
    return w[31:0];
  endfunction

  function automatic logic model_err(input int fmt, input logic [31:0] imm);
    int s = signed'(imm);
    if (!RC) return 1'b0;
    case (fmt)
      1, 2:    return (s < -2048) || (s > 2047);
      3:       return (s < -4096) || (s > 4095) || (s % 2 != 0);
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    logic [31:0] held_instr;
    logic [31:0] exp_r;
    bit          m_valid;
    logic [31:0] m_instr, m_addr, m_pc;
    logic        m_err;

    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    if_a.out_ready = 1'b1;
    if_b.in_valid = 1'b0;  if_b.in_fmt = 2'd0;  if_b.in_funct3 = 3'd0;
    if_b.in_funct7 = 7'd0; if_b.in_rd = 5'd0;   if_b.in_rs1 = 5'd0;
    if_b.in_rs2 = 5'd0;    if_b.in_imm = 32'h0; if_b.out_ready = 1'b1;

    #3;
    check("rst_out_valid", 32'(if_a.out_valid), 32'd0);
    check("rst_out_instr", if_a.out_instr, 32'h0);
    check("rst_out_addr",  if_a.out_addr,  32'h0);
    check("rst_out_err",   32'(if_a.out_err), 32'd0);
    check("rst_in_ready",  32'(if_a.in_ready), 32'd1);
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    drive(1, 0, 0, 0, 3, 1, 2, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("r_valid", 32'(if_a.out_valid), 32'd1);
    check("r_instr", if_a.out_instr, 32'h002081B3);
    check("r_addr",  if_a.out_addr,  32'h0);
    check("r_err",   32'(if_a.out_err), 32'd0);
    tick();
    check("drain_valid", 32'(if_a.out_valid), 32'd0);

    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;

    drive(1, 1, 0, 0, 5, 0, 0, 32'hFFFF_FFFF);
    tick();
    check("i_instr", if_a.out_instr, 32'hFFF00293);
    check("i_addr",  if_a.out_addr,  32'h0);
    drive(1, 2, 2, 0, 0, 1, 2, 32'd8);
    tick();
    check("s_valid", 32'(if_a.out_valid), 32'd1);
    check("s_instr", if_a.out_instr, 32'h0020A423);
    check("s_addr",  if_a.out_addr,  32'h4);
    drive(1, 3, 0, 0, 0, 1, 2, 32'hFFFF_FFFC);
    tick();
    check("b_instr", if_a.out_instr, 32'hFE208EE3);
    check("b_addr",  if_a.out_addr,  32'h8);
    check("b_err",   32'(if_a.out_err), 32'd0);

    drive(1, 1, 0, 0, 0, 0, 0, 32'd2048);
    tick();
    check("i2048_err",  32'(if_a.out_err), 32'(RC));
    check("i2048_imm",  32'(if_a.out_instr[31:20]), 32'h800);
    drive(1, 3, 0, 0, 0, 1, 2, 32'd6);
    tick();
    check("b6_err", 32'(if_a.out_err), 32'd0);
    drive(1, 3, 0, 0, 0, 1, 2, 32'd5);
    tick();
    check("b5_err",   32'(if_a.out_err), 32'(RC));
    check("b5_instr", if_a.out_instr, model_word(3, 0, 0, 0, 1, 2, 32'd5));
    held_instr = model_word(3, 0, 0, 0, 1, 2, 32'd5);

    if_a.out_ready = 1'b0;
    drive(1, 0, 1, 32, 7, 8, 9, 32'h0);
    exp_r = model_word(0, 1, 32, 7, 8, 9, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 32'(if_a.in_ready), 32'd0);
      tick();
      check("bp_instr", if_a.out_instr, held_instr);
      check("bp_addr",  if_a.out_addr,  32'd20);
    end
    if_a.out_ready = 1'b1;
    #1;
    check("rel_in_ready", 32'(if_a.in_ready), 32'd1);
    tick();
    check("rel_instr", if_a.out_instr, exp_r);
    check("rel_addr",  if_a.out_addr,  32'd24);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    tick();
    check("rel_drain", 32'(if_a.out_valid), 32'd0);

    m_valid = 1'b0;
    m_instr = 32'h0;
    m_addr  = 32'h0;
    m_err   = 1'b0;
    m_pc    = 32'd28;
    for (int n = 0; n < 300; n++) begin
      int          fmt, f3, f7, rd, rs1, rs2;
      logic [31:0] imm;
      bit          v, ordy, acc;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fmt  = $urandom_range(0, 3);
      f3   = $urandom_range(0, 7);
      f7   = $urandom_range(0, 127);
      rd   = $urandom_range(0, 31);
      rs1  = $urandom_range(0, 31);
      rs2  = $urandom_range(0, 31);
      imm  = ($urandom_range(0, 1) != 0) ? 32'($urandom)
                                         : 32'(int'($urandom_range(0, 10000)) - 5000);
      drive(v, fmt, f3, f7, rd, rs1, rs2, imm);
      if_a.out_ready = ordy;
      #1;
      check("rnd_in_ready", 32'(if_a.in_ready), 32'(!m_valid || ordy));
      acc = v && (!m_valid || ordy);
      tick();
      if (acc) begin
        m_valid = 1'b1;
        m_instr = model_word(fmt, f3, f7, rd, rs1, rs2, imm);
        m_err   = model_err(fmt, imm);
        m_addr  = m_pc;
        m_pc    = m_pc + 32'd4;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      check("rnd_valid", 32'(if_a.out_valid), 32'(m_valid));
      if (m_valid) begin
        check("rnd_instr", if_a.out_instr, m_instr);
        check("rnd_addr",  if_a.out_addr,  m_addr);
        check("rnd_err",   32'(if_a.out_err), 32'(m_err));
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);

    if_b.in_valid = 1'b1;
    tick();
    check("wrap_addr0", if_b.out_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", if_b.out_addr, 32'h0000_0000);
    if_b.in_valid  = 1'b0;
    if_b.out_ready = 1'b0;
    tick();
    check("wrap_full", 32'(if_b.out_valid), 32'd1);
    rst_b = 1'b1;
    #1;
    check("async_rst_valid", 32'(if_b.out_valid), 32'd0);
    check("async_rst_addr",  if_b.out_addr, 32'h0);
    tick();
    rst_b = 1'b0;
    if_b.out_ready = 1'b1;
    tick();
    check("post_rst_valid", 32'(if_b.out_valid), 32'd0);
    if_b.in_valid = 1'b1;
    tick();
    if_b.in_valid = 1'b0;
    check("post_rst_addr", if_b.out_addr, 32'hFFFF_FFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
